// File: rtl/rgbled_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgbled_pkg
// Brief    : Shared constants, FSM state type and channel scaling for the
//            RGB LED frame controller.
// Revision : 1.0
// ============================================================================
package rgbled_pkg;

  localparam int BIT_CYCLES = 32;
  localparam int RESET_BITS = 42;
  localparam int CHAN_W     = 8;
  localparam int PIXEL_W    = 3 * CHAN_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_RES  = 2'd1,
    RUN_DATA = 2'd2
  } state_e;

  // (c * (b + 1)) >> 8: b = 255 is identity, b = 0 is black.
  function automatic logic [CHAN_W-1:0] scale_chan(input logic [CHAN_W-1:0] c,
                                                   input logic [CHAN_W-1:0] b);
    return CHAN_W'(({{CHAN_W{1'b0}}, c} *
                     ({{CHAN_W{1'b0}}, b} + (2 * CHAN_W)'(1))) >> CHAN_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgbled_phase_tracker.sv
`default_nettype none
// ============================================================================
// Module   : rgbled_phase_tracker
// Brief    : Bit-exact mirror of the LED driver's tcnt/bcnt counters; flags the
//            last cycle of the reset gap and of the data phase.
// Revision : 1.0
// ============================================================================
module rgbled_phase_tracker
  import rgbled_pkg::*;
#(
  parameter int LEDS = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  input  logic in_data_i,
  output logic res_end_o,
  output logic data_end_o
);

  localparam int DATA_BITS = LEDS * PIXEL_W;
  localparam int BCNT_MAX  = (DATA_BITS > RESET_BITS) ? DATA_BITS : RESET_BITS;
  localparam int BCNT_W    = $clog2(BCNT_MAX);
  localparam int TCNT_W    = $clog2(BIT_CYCLES);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(BIT_CYCLES - 1);
  localparam logic [BCNT_W-1:0] RES_LAST  = BCNT_W'(RESET_BITS - 1);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_BITS - 1);

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              bit_end;
  logic              phase_last;

  always_comb begin : p_next
    bit_end    = (tcnt_q == TCNT_LAST);
    phase_last = in_data_i ? (bcnt_q == DATA_LAST) : (bcnt_q == RES_LAST);
    res_end_o  = run_i & ~in_data_i & bit_end & phase_last;
    data_end_o = run_i &  in_data_i & bit_end & phase_last;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    // The driver holds both counters at zero whenever data_rdy is low.
    if (!run_i) begin
      tcnt_d = '0;
      bcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TCNT_W'(1);
      if (bit_end) begin
        bcnt_d = phase_last ? '0 : bcnt_q + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin : p_regs
    if (reset_i) begin
      tcnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      bcnt_q <= bcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgbled_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rgbled_frame_ctrl
// Brief    : Shadow-buffered frame controller; swaps committed frames into the
//            driver bus only in the reset gap. RGBLED_BRIGHTNESS_EN adds bright_i.
// Revision : 1.0
// ============================================================================
module rgbled_frame_ctrl
  import rgbled_pkg::*;
#(
  parameter int LEDS         = 4,
  parameter int BITS_PER_LED = 24
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [$clog2(LEDS)-1:0] wr_addr_i,
  input  logic [PIXEL_W-1:0]      wr_data_i,
  input  logic                    commit_i,
  input  logic                    enable_i,
`ifdef RGBLED_BRIGHTNESS_EN
  input  logic [CHAN_W-1:0]       bright_i,
`endif
  output logic                    commit_pending_o,
  output logic [LEDS*PIXEL_W-1:0] led_data_o,
  output logic                    led_data_rdy_o,
  output logic                    frame_done_o
);

  localparam int            AW     = $clog2(LEDS);
  localparam int            LW     = LEDS * PIXEL_W;
  localparam logic [AW:0]   LEDS_A = (AW + 1)'(LEDS);

  if (BITS_PER_LED != PIXEL_W) begin : g_bad_bits_per_led
    $error("rgbled_frame_ctrl: BITS_PER_LED must be 24");
  end

  state_e          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic            fd_q, fd_d;
  logic            pend_q, pend_d;
  logic            ready_q, ready_d;
  logic [LW-1:0]   shadow_q, shadow_d;
  logic [LW-1:0]   led_q, led_d;
  logic [LW-1:0]   frame_img;
  logic            commit_acc;
  logic            copy;
  logic            res_end;
  logic            data_end;

  rgbled_phase_tracker #(
    .LEDS (LEDS)
  ) u_phase (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .run_i      (rdy_q),
    .in_data_i  (state_q == RUN_DATA),
    .res_end_o  (res_end),
    .data_end_o (data_end)
  );

  // Out-of-range addresses complete the handshake but leave the shadow intact.
  always_comb begin : p_shadow
    shadow_d = shadow_q;
    if (wr_valid_i && ready_q && ({1'b0, wr_addr_i} < LEDS_A)) begin
      shadow_d[wr_addr_i*PIXEL_W +: PIXEL_W] = wr_data_i;
    end
  end

`ifdef RGBLED_BRIGHTNESS_EN
  for (genvar c = 0; c < LEDS * 3; c++) begin : g_chan
    assign frame_img[c*CHAN_W +: CHAN_W] = scale_chan(shadow_d[c*CHAN_W +: CHAN_W], bright_i);
  end
`else
  assign frame_img = shadow_d;
`endif

  always_comb begin : p_fsm
    state_d    = state_q;
    fd_d       = 1'b0;
    commit_acc = commit_i & ~pend_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i) state_d = RUN_RES;
      end
      RUN_RES: begin
        if (!enable_i)    state_d = IDLE;
        else if (res_end) state_d = RUN_DATA;
      end
      RUN_DATA: begin
        if (data_end) begin
          state_d = enable_i ? RUN_RES : IDLE;
          fd_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outside the data phase a commit lands at once; inside it waits for the
    // frame-end edge, which a commit arriving on that very edge also shares.
    copy    = (commit_acc & (state_q != RUN_DATA)) | (data_end & (commit_acc | pend_q));
    pend_d  = data_end ? 1'b0 : (pend_q | (commit_acc & (state_q == RUN_DATA)));
    ready_d = ~pend_d;
    rdy_d   = (state_d != IDLE);
    led_d   = copy ? frame_img : led_q;
  end

  always_ff @(posedge clk_i) begin : p_regs
    if (reset_i) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      fd_q     <= 1'b0;
      pend_q   <= 1'b0;
      ready_q  <= 1'b0;
      shadow_q <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      fd_q     <= fd_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign wr_ready_o       = ready_q;
  assign commit_pending_o = pend_q;
  assign led_data_o       = led_q;
  assign led_data_rdy_o   = rdy_q;
  assign frame_done_o     = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_rgbled_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgbled_frame_ctrl
// Brief    : Self-checking bench: vector table, directed frame sequences and
//            random traffic against a phase/position reference model.
// Revision : 1.0
// ============================================================================
module tb_rgbled_frame_ctrl;

  localparam int LEDS     = 4;
  localparam int LW       = LEDS * 24;
  localparam int GAP_LEN  = 42 * 32;
  localparam int DATA_LEN = LEDS * 24 * 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, wr_valid, commit, enable;
  logic [1:0]    wr_addr;
  logic [23:0]   wr_data;
  logic          wr_ready, commit_pending, led_data_rdy, frame_done;
  logic [LW-1:0] led_data;
`ifdef RGBLED_BRIGHTNESS_EN
  logic [7:0]    bright;
`endif

  logic          reset5, wr_valid5, commit5;
  logic [2:0]    wr_addr5;
  logic [23:0]   wr_data5;
  logic          wr_ready5, commit_pending5, led_data_rdy5, frame_done5;
  logic [119:0]  led_data5;

  rgbled_frame_ctrl #(.LEDS(LEDS), .BITS_PER_LED(24)) u_dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .wr_valid_i       (wr_valid),
    .wr_ready_o       (wr_ready),
    .wr_addr_i        (wr_addr),
    .wr_data_i        (wr_data),
    .commit_i         (commit),
    .enable_i         (enable),
`ifdef RGBLED_BRIGHTNESS_EN
    .bright_i         (bright),
`endif
    .commit_pending_o (commit_pending),
    .led_data_o       (led_data),
    .led_data_rdy_o   (led_data_rdy),
    .frame_done_o     (frame_done)
  );

  rgbled_frame_ctrl #(.LEDS(5), .BITS_PER_LED(24)) u_dut5 (
    .clk_i            (clk),
    .reset_i          (reset5),
    .wr_valid_i       (wr_valid5),
    .wr_ready_o       (wr_ready5),
    .wr_addr_i        (wr_addr5),
    .wr_data_i        (wr_data5),
    .commit_i         (commit5),
    .enable_i         (1'b0),
`ifdef RGBLED_BRIGHTNESS_EN
    .bright_i         (8'd255),
`endif
    .commit_pending_o (commit_pending5),
    .led_data_o       (led_data5),
    .led_data_rdy_o   (led_data_rdy5),
    .frame_done_o     (frame_done5)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: phase (0 idle, 1 reset gap, 2 data) plus cycle position.
  logic [23:0] m_shadow [LEDS];
  logic [23:0] m_active [LEDS];
  int          m_phase, m_pos;
  bit          m_pend, m_ready, m_fd;

  function automatic logic [23:0] dim(input logic [23:0] px);
`ifdef RGBLED_BRIGHTNESS_EN
    logic [23:0] r;
    for (int c = 0; c < 3; c++) begin
      int v;
      v = int'(px[c*8 +: 8]);
      r[c*8 +: 8] = 8'((v * (int'(bright) + 1)) / 256);
    end
    return r;
`else
    return px;
`endif
  endfunction

  function automatic logic [LW-1:0] pack_active();
    logic [LW-1:0] r;
    for (int i = 0; i < LEDS; i++) r[i*24 +: 24] = m_active[i];
    return r;
  endfunction

  task automatic model_step();
    bit end_gap, end_data, acc;
    if (reset) begin
      foreach (m_shadow[i]) begin m_shadow[i] = '0; m_active[i] = '0; end
      m_phase = 0; m_pos = 0; m_pend = 0; m_ready = 0; m_fd = 0;
      return;
    end
    end_gap  = (m_phase == 1) && (m_pos == GAP_LEN - 1);
    end_data = (m_phase == 2) && (m_pos == DATA_LEN - 1);
    if (wr_valid && m_ready) m_shadow[wr_addr] = wr_data;
    acc = commit && !m_pend;
    if ((acc && (m_phase != 2 || end_data)) || (m_pend && end_data))
      foreach (m_active[i]) m_active[i] = dim(m_shadow[i]);
    if (end_data) m_pend = 0;
    else if (acc && m_phase == 2) m_pend = 1;
    m_fd    = end_data;
    m_ready = !m_pend;
    case (m_phase)
      0: if (enable) begin m_phase = 1; m_pos = 0; end
      1: begin
        if (!enable) m_phase = 0;
        else if (end_gap) begin m_phase = 2; m_pos = 0; end
        else m_pos++;
      end
      default: begin
        if (end_data) begin m_phase = enable ? 1 : 0; m_pos = 0; end
        else m_pos++;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model", 128'({led_data_rdy, commit_pending, wr_ready, frame_done, led_data}),
          128'({m_phase != 0, m_pend, m_ready, m_fd, pack_active()}));
  endtask

  typedef struct {
    bit          rst, wv;
    logic [1:0]  wa;
    logic [23:0] wd;
    bit          cm, en;
    bit          e_ready, e_rdy;
    logic [LW-1:0] e_led;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n, bad;
    reset = 1; wr_valid = 0; wr_addr = '0; wr_data = '0; commit = 0; enable = 0;
    reset5 = 1; wr_valid5 = 0; wr_addr5 = '0; wr_data5 = '0; commit5 = 0;
`ifdef RGBLED_BRIGHTNESS_EN
    bright = 8'd255;
`endif

    vecs[0] = '{1'b1, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    vecs[1] = '{1'b0, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, '0};
    vecs[2] = '{1'b0, 1'b1, 2'd0, 24'hFF0000, 1'b0, 1'b0, 1'b1, 1'b0, '0};
    vecs[3] = '{1'b0, 1'b1, 2'd1, 24'h00FF00, 1'b1, 1'b0, 1'b1, 1'b0,
                {24'h000000, 24'h000000, 24'h00FF00, 24'hFF0000}};
    vecs[4] = '{1'b0, 1'b1, 2'd3, 24'h0000FF, 1'b0, 1'b0, 1'b1, 1'b0,
                {24'h000000, 24'h000000, 24'h00FF00, 24'hFF0000}};
    vecs[5] = '{1'b0, 1'b0, 2'd0, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0,
                {24'h0000FF, 24'h000000, 24'h00FF00, 24'hFF0000}};
    vecs[6] = '{1'b0, 1'b1, 2'd2, 24'h123456, 1'b1, 1'b0, 1'b1, 1'b0,
                {24'h0000FF, 24'h123456, 24'h00FF00, 24'hFF0000}};
    vecs[7] = '{1'b0, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1,
                {24'h0000FF, 24'h123456, 24'h00FF00, 24'hFF0000}};
    vecs[8] = '{1'b0, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0,
                {24'h0000FF, 24'h123456, 24'h00FF00, 24'hFF0000}};
    vecs[9] = '{1'b1, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, '0};

    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst; wr_valid = vecs[i].wv; wr_addr = vecs[i].wa;
      wr_data = vecs[i].wd; commit = vecs[i].cm; enable = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), 128'({wr_ready, led_data_rdy, led_data}),
            128'({vecs[i].e_ready, vecs[i].e_rdy, vecs[i].e_led}));
    end
    reset = 0; wr_valid = 0; commit = 0; enable = 0;

    // Commit in idle, then time a full refresh period.
    tick();
    wr_valid = 1; wr_addr = 2'd0; wr_data = 24'hFF0000; commit = 1;
    tick();
    wr_valid = 0; commit = 0;
    check("commit_idle", 128'(led_data[23:0]), 128'(24'hFF0000));
    check("commit_idle_pend", 128'(commit_pending), 128'(1'b0));
    enable = 1;
    tick();
    check("rdy_rise", 128'(led_data_rdy), 128'(1'b1));
    n = 0;
    while (!frame_done && n < 5000) begin tick(); n++; end
    check("frame_len", 128'(n), 128'(4416));

    // Commit at data-phase cycle 100 is deferred to the frame_done edge.
    wr_valid = 1; wr_addr = 2'd1; wr_data = 24'hABCDEF;
    tick();
    wr_valid = 0;
    repeat (GAP_LEN + 99) tick();
    commit = 1;
    tick();
    commit = 0;
    check("pend_set", 128'({commit_pending, wr_ready}), 128'(2'b10));
    check("led_held", 128'(led_data[47:24]), 128'(24'h0));
    n = 0;
    while (!frame_done && n < 5000) begin tick(); n++; end
    check("pend_len", 128'(n), 128'(2971));
    check("led_swapped", 128'(led_data[47:24]), 128'(24'hABCDEF));
    check("pend_clear", 128'({commit_pending, wr_ready}), 128'(2'b01));

    // enable dropped mid data phase: frame completes before idling.
    repeat (GAP_LEN + 10) tick();
    enable = 0;
    n = 0; bad = 0;
    while (!frame_done && n < 5000) begin
      if (!led_data_rdy) bad++;
      tick(); n++;
    end
    check("rdy_hold", 128'(bad), 128'(0));
    check("rdy_drop_end", 128'({frame_done, led_data_rdy}), 128'(2'b10));
    enable = 1;
    tick();
    repeat (20) tick();
    enable = 0;
    tick();
    check("rdy_drop_gap", 128'(led_data_rdy), 128'(1'b0));

    // Reset during the data phase with a commit pending.
    enable = 1;
    repeat (GAP_LEN + 50) tick();
    wr_valid = 1; wr_addr = 2'd2; wr_data = 24'h55AA55; commit = 1;
    tick();
    wr_valid = 0; commit = 0;
    check("pend_before_rst", 128'(commit_pending), 128'(1'b1));
    reset = 1;
    tick();
    reset = 0;
    check("mid_reset", 128'({led_data, led_data_rdy, commit_pending, wr_ready}), 128'(0));

    // Randomised traffic against the model.
    for (int i = 0; i < 8000; i++) begin
      reset    = ($urandom_range(0, 4999) == 0);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_addr  = 2'($urandom);
      wr_data  = 24'($urandom);
      commit   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1499) == 0) enable = ~enable;
`ifdef RGBLED_BRIGHTNESS_EN
      bright   = 8'($urandom);
`endif
      tick();
    end

    // Out-of-range address on a five-pixel chain.
    reset = 1; wr_valid = 0; commit = 0; enable = 0;
    tick();
    reset = 0;
    reset5 = 0;
    tick();
    check("oob_ready", 128'(wr_ready5), 128'(1'b1));
    wr_valid5 = 1; wr_addr5 = 3'd4; wr_data5 = 24'h111111; commit5 = 1;
    tick();
    wr_valid5 = 0; commit5 = 0;
    check("leds5_commit", 128'(led_data5), 128'({24'h111111, 96'h0}));
    wr_valid5 = 1; wr_addr5 = 3'd5; wr_data5 = 24'h222222;
    tick();
    wr_addr5 = 3'd7; wr_data5 = 24'h333333;
    check("oob_accept", 128'(wr_ready5), 128'(1'b1));
    tick();
    wr_valid5 = 0; commit5 = 1;
    tick();
    commit5 = 0;
    check("oob_discard", 128'(led_data5), 128'({24'h111111, 96'h0}));

`ifdef RGBLED_BRIGHTNESS_EN
    bright = 8'd127;
    wr_valid = 1; wr_addr = 2'd0; wr_data = 24'hFF8040; commit = 1;
    tick();
    wr_valid = 0; commit = 0;
    check("bright127", 128'(led_data[23:0]), 128'(24'h7F4020));
    bright = 8'd255;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgbled_frame_ctrl.md
# rgbled_frame_ctrl

Frame controller for the serial RGB LED driver. Host writes land in a shadow pixel buffer through a valid/ready port. The controller owns the driver's `data` bus and `data_rdy` strobe. It mirrors the driver's bit timing, so a committed frame is swapped into the active bus only while the driver is in its reset gap, which makes tearing impossible.

## Interface
- `LEDS`, 4: number of pixels in the chain.
- `BITS_PER_LED`, 24: fixed at 24 (GRB, 8 bits per channel); any other value is an elaboration error.
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high reset.
- `wr_valid`  in  1: pixel write request.
- `wr_ready`  out  1: shadow buffer accepts a write.
- `wr_addr`  in  `$clog2(LEDS)`: pixel index.
- `wr_data`  in  24: GRB pixel value, G in [23:16].
- `commit`  in  1: request to present the shadow buffer as the next frame.
- `enable`  in  1: refresh enable.
- `bright`  in  8: global brightness; port exists only with `RGBLED_BRIGHTNESS_EN`.
- `commit_pending`  out  1: commit accepted but not yet applied.
- `led_data`  out  `LEDS*24`: driver `data` bus; pixel i occupies [24i+23:24i].
- `led_data_rdy`  out  1: driver `data_rdy`.
- `frame_done`  out  1: one-cycle pulse when a data phase ends.

## Operation
- States: IDLE (`led_data_rdy`=0), RUN_RES (driver reset gap), RUN_DATA (driver shifting bits).
- Mirror counters: `tcnt` (5 bits, wraps 31→0) and `bcnt`. Both are held at 0 while `led_data_rdy`=0, so they are bit-exact with the driver.
- IDLE→RUN_RES when `enable`=1.
- RUN_RES→RUN_DATA at the `tcnt`=31 edge with `bcnt`=41.
- RUN_DATA→RUN_RES at the `tcnt`=31 edge with `bcnt`=LEDS*24−1. `frame_done` pulses at this edge.
- Leaving RUN_DATA with `enable`=0 goes to IDLE instead of RUN_RES; `frame_done` still pulses.
- `enable`=0 in RUN_RES → IDLE at the next edge.
- `enable` is ignored inside RUN_DATA; a frame is never truncated.
- Write handshake:
  - A transfer occurs on `wr_valid & wr_ready`.
  - `wr_ready` = !`commit_pending`; it is forced to 0 in the reset cycle.
  - `wr_addr` ≥ LEDS: the write is accepted and discarded.
- Commit rules:
  - Commit in IDLE or RUN_RES: the shadow is copied to `led_data` at that same edge and `commit_pending` stays 0.
  - Commit in RUN_DATA: `commit_pending` is set. The copy happens at the RUN_DATA→RUN_RES/IDLE edge and `commit_pending` clears there.
  - Commit while `commit_pending`=1 is ignored.
  - A write and a commit in the same cycle: the write is included in the committed frame.
- Initial content: shadow and `led_data` reset to all zeros. Refresh with no commit emits black.

## Timing
- Reset values: `led_data`=0, `led_data_rdy`=0, `frame_done`=0, `commit_pending`=0, `wr_ready`=0, state IDLE, counters 0. `wr_ready`=1 from the first cycle after reset.
- `led_data_rdy` rises one edge after `enable` is sampled high in IDLE.
- Reset gap: 42×32 = 1344 cycles. Data phase: LEDS×24×32 cycles (3072 at default). Period: 4416 cycles.
- Reset asserted mid-frame: all state returns to reset values at that edge and the driver output drops immediately.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `RGBLED_BRIGHTNESS_EN` defined:
  - `bright` port present.
  - Each channel is copied as (c × (`bright`+1)) >> 8.
  - `bright` is sampled at the copy edge.
  - `bright`=255 gives identity; `bright`=0 gives c>>8 = 0.
- `RGBLED_BRIGHTNESS_EN` undefined: no `bright` port; the copy is verbatim.

## Structure
- `rgbled_pkg` holds:
  - constants `BIT_CYCLES`=32, `RESET_BITS`=42, `CHAN_W`=8;
  - state enum {IDLE, RUN_RES, RUN_DATA};
  - the channel-scaling function.
- Sub-module `rgbled_phase_tracker` holds the mirror `tcnt`/`bcnt` and outputs `res_end` and `data_end` strobes.

## Test plan
- Reset, write pixel 0 = 0xFF0000, commit in IDLE, raise `enable` → `led_data`[23:0]=0xFF0000 at the commit edge; `led_data_rdy` high one edge after `enable`; first `frame_done` 4416 cycles after `led_data_rdy` rises.
- Commit issued at data-phase cycle 100 → `commit_pending`=1 and `wr_ready`=0 until the `frame_done` edge; `led_data` is unchanged before that edge and updated at it.
- Drop `enable` mid data phase → `led_data_rdy` stays high until the `frame_done` edge, then 0; drop it in the reset gap → 0 one edge later.
- Write to `wr_addr`=5 with LEDS=5 (3-bit address), then commit → write accepted, `led_data` unchanged.
- Assert `reset` during the data phase → next cycle `led_data`=0, `led_data_rdy`=0, `commit_pending`=0.
- `RGBLED_BRIGHTNESS_EN`, `bright`=127, pixel 0xFF8040, commit → `led_data` pixel = 0x7F4020.
